// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf output arbiter: packet field layout, FSM states
// and the packet formatter.
package leaf_pkg;

  localparam int unsigned PKT_W  = 49;
  localparam int unsigned PAY_W  = 32;
  localparam int unsigned LEAF_W = 5;
  localparam int unsigned PORT_W = 4;
  localparam int unsigned SEQ_W  = 7;

  localparam int unsigned VALID_BIT = 48;
  localparam int unsigned LEAF_LSB  = 43;
  localparam int unsigned PORT_LSB  = 39;
  localparam int unsigned SEQ_LSB   = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  function automatic logic [PKT_W-1:0] pack_packet(
    input logic [LEAF_W-1:0] leaf,
    input logic [PORT_W-1:0] port,
    input logic [SEQ_W-1:0]  seq,
    input logic [PAY_W-1:0]  payload
  );
    logic [PKT_W-1:0] p;
    p                      = '0;
    p[VALID_BIT]           = 1'b1;
    p[LEAF_LSB +: LEAF_W]  = leaf;
    p[PORT_LSB +: PORT_W]  = port;
    p[SEQ_LSB +: SEQ_W]    = seq;
    p[0 +: PAY_W]          = payload;
    return p;
  endfunction

endpackage

// File: rtl/rr_prio_arb.sv
// Combinational N-way round-robin picker: first requester at or after ptr,
// wrapping circularly. One-hot grant plus valid.
module rr_prio_arb #(
  parameter int unsigned N  = 7,
  parameter int unsigned PW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          gnt_vld
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] hi_req;
  logic [N-1:0] pick;

  // Requests at or above ptr win; otherwise wrap to the lowest requester.
  always_comb begin
    hi_mask = '0;
    for (int unsigned j = 0; j < N; j++) begin
      hi_mask[j] = (PW'(j) >= ptr);
    end
    hi_req  = req & hi_mask;
    pick    = (|hi_req) ? hi_req : req;
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (pick[j] && !gnt_vld) begin
        gnt[j]  = 1'b1;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter sharing the leaf-to-BFT packet link among user output streams,
// with per-port credits and destinations. Optional statistics: LEAF_ARB_STATS_EN.
module leaf_out_arbiter #(
  parameter int unsigned PACKET_BITS           = 49,
  parameter int unsigned PAYLOAD_BITS          = 32,
  parameter int unsigned NUM_LEAF_BITS         = 5,
  parameter int unsigned NUM_PORT_BITS         = 4,
  parameter int unsigned NUM_ADDR_BITS         = 7,
  parameter int unsigned NUM_OUT_PORTS         = 7,
  parameter int unsigned CREDIT_INIT           = 128,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user,
  output logic [NUM_OUT_PORTS-1:0]                ack_user,
  input  logic                                    cfg_we,
  input  logic [NUM_PORT_BITS-1:0]                cfg_port,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dest,
  input  logic                                    cfg_done,
  input  logic                                    credit_upd,
  input  logic [NUM_PORT_BITS-1:0]                credit_port,
  input  logic                                    resend,
  output logic [PACKET_BITS-1:0]                  dout_bft,
`ifdef LEAF_ARB_STATS_EN
  output logic [NUM_OUT_PORTS*32-1:0]             stat_sent,
  output logic [31:0]                             stat_stall,
`endif
  output logic                                    busy
);

  import leaf_pkg::*;

  localparam int unsigned CW = $clog2(CREDIT_INIT + 1);
  localparam int unsigned XW = $clog2(CREDIT_INIT + FREESPACE_UPDATE_SIZE + 1);
  localparam int unsigned DW = NUM_LEAF_BITS + NUM_PORT_BITS;

  state_t                   state;
  logic [NUM_PORT_BITS-1:0] rr_ptr;
  logic [NUM_PORT_BITS-1:0] ptr_nxt;
  logic [CW-1:0]            credit     [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_nxt [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq        [NUM_OUT_PORTS];
  logic [DW-1:0]            dest_tbl   [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0] elig;
  logic [NUM_OUT_PORTS-1:0] req;
  logic [NUM_OUT_PORTS-1:0] gnt;
  logic [NUM_OUT_PORTS-1:0] upd_hit;
  logic                     fire;
  logic                     grant_en;

  logic [DW-1:0]            sel_dest;
  logic [NUM_ADDR_BITS-1:0] sel_seq;
  logic [PAYLOAD_BITS-1:0]  sel_data;

  assign grant_en = (state == RUN) && cfg_done && !resend;

  always_comb begin
    elig    = '0;
    upd_hit = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      elig[i]    = vld_user[i] && (credit[i] != '0);
      upd_hit[i] = credit_upd && (credit_port == NUM_PORT_BITS'(i));
    end
  end

  assign req = elig & {NUM_OUT_PORTS{grant_en}};

  rr_prio_arb #(
    .N  (NUM_OUT_PORTS),
    .PW (NUM_PORT_BITS)
  ) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_vld (fire)
  );

  assign ack_user = gnt;
  assign busy     = (state == RUN) && (|vld_user);

  always_comb begin
    sel_dest = '0;
    sel_seq  = '0;
    sel_data = '0;
    ptr_nxt  = rr_ptr;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      if (gnt[i]) begin
        sel_dest = dest_tbl[i];
        sel_seq  = seq[i];
        sel_data = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        ptr_nxt  = (i == NUM_OUT_PORTS - 1) ? '0 : NUM_PORT_BITS'(i + 1);
      end
    end
  end

  // Grant and update on one port in the same cycle net out before saturation.
  always_comb begin
    logic [XW-1:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = XW'(credit[i]);
      if (gnt[i])     sum = sum - XW'(1);
      if (upd_hit[i]) sum = sum + XW'(FREESPACE_UPDATE_SIZE);
      if (sum > XW'(CREDIT_INIT)) sum = XW'(CREDIT_INIT);
      credit_nxt[i] = CW'(sum);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE:    if (cfg_done) state <= RUN;
        RUN: begin
          if (!cfg_done)   state <= IDLE;
          else if (resend) state <= PAUSE;
        end
        PAUSE:   if (!resend) state <= RUN;
        default: state <= IDLE;
      endcase
      if (fire) rr_ptr <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_bft <= '0;
    end else if (fire) begin
      dout_bft <= pack_packet(sel_dest[DW-1:NUM_PORT_BITS], sel_dest[NUM_PORT_BITS-1:0],
                              sel_seq, sel_data);
    end else begin
      dout_bft <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i]   <= CW'(CREDIT_INIT);
        seq[i]      <= '0;
        dest_tbl[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_nxt[i];
        if (gnt[i]) seq[i] <= seq[i] + 1'b1;
        if (cfg_we && (cfg_port == NUM_PORT_BITS'(i))) dest_tbl[i] <= cfg_dest;
      end
    end
  end

`ifdef LEAF_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_sent  <= '0;
      stat_stall <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        if (gnt[i]) stat_sent[i*32 +: 32] <= stat_sent[i*32 +: 32] + 32'd1;
      end
      if ((state == RUN) && (|vld_user) && !(|elig)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
